// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter in front of the data memory.
// m0 is the core, m1 is the UART DMA. A granted master keeps the bus for as
// long as it holds cyc, which locks multi-transfer bursts. If the memory does
// not ack within TIMEOUT strobed cycles, the owner receives a one-cycle error.
module data_mem_arbiter #(
  parameter int TIMEOUT = 15  // legal range 2..255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  // master 0 (core)
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  // master 1 (UART DMA)
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  // data memory
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  // grant status
  output logic [1:0] gnt_o
);

  // The encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic       last_owner;   // 1 = m1 owned the bus last
  logic [7:0] wait_cnt;

  // Signals of whichever master currently owns the bus (all 0 in IDLE).
  logic       own_cyc;
  logic       own_stb;
  logic       own_we;
  logic [7:0] own_adr;
  logic [7:0] own_dat;
  logic       timeout_hit;

  // State register; reset forces IDLE immediately, aborting any transfer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: round-robin on ties from IDLE, no preemption, direct handoff.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_owner ? G0 : G1;
        else if (m0_cyc_i)        state_next = G0;
        else if (m1_cyc_i)        state_next = G1;
      end
      G0: begin
        if (!m0_cyc_i) state_next = m1_cyc_i ? G1 : IDLE;
      end
      G1: begin
        if (!m1_cyc_i) state_next = m0_cyc_i ? G0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Owner mux: selects the granted master's request lines.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = 8'h00;
    own_dat = 8'h00;
    case (state)
      G0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i & m0_cyc_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      G1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i & m1_cyc_i;
        own_we  = m1_we_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Error fires only when the ack is absent, so ack and err are exclusive.
  assign timeout_hit = own_stb & ~s_ack_i & (wait_cnt == TIMEOUT_LAST);

  // Last owner and ack wait counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_owner <= 1'b1;  // m0 wins the first tie
      wait_cnt   <= 8'h00;
    end else begin
      if (state_next != state) begin
        if (state_next == G0) last_owner <= 1'b0;
        if (state_next == G1) last_owner <= 1'b1;
      end
      if (state_next != state || !own_stb || s_ack_i || timeout_hit)
        wait_cnt <= 8'h00;
      else
        wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // Output decode: memory side mirrors the owner, responses go to the owner.
  always_comb begin
    gnt_o    = state;
    s_cyc_o  = own_cyc;
    s_stb_o  = own_stb;
    s_we_o   = own_we;
    s_adr_o  = own_adr;
    s_dat_o  = own_dat;
    m0_dat_o = 8'h00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = 8'h00;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      G0: begin
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout_hit;
      end
      G1: begin
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory:
// writes ack in their first strobed cycle, reads ack one cycle later.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m0_cyc_i, m0_stb_i, m0_we_i;
  logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic       s_ack_i;
  logic [1:0] gnt_o;

  int checks = 0;
  int errors = 0;

  // memory model controls
  logic       preload;
  logic       ack_en;
  logic       rd_ack;
  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o)
  );

  // Memory model: preload pattern adr^0x3C, then accept acked writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else if (s_stb_o && s_we_o && s_ack_i) begin
      mem[s_adr_o] <= s_dat_o;
    end
  end

  // Read ack arrives in the cycle after the strobe is first seen.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) rd_ack <= 1'b0;
    else       rd_ack <= s_stb_o && !s_we_o && !rd_ack;
  end

  assign s_ack_i = ack_en & s_stb_o & (s_we_o | rd_ack);
  assign s_dat_i = mem[s_adr_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_m0(input logic c, input logic s, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
  endtask

  task automatic drive_m1(input logic c, input logic s, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
  endtask

  // advance to the middle of the next cycle
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int first_err;
    int err_cnt;
    logic ack_seen;

    rst_i   = 1'b1;
    preload = 1'b1;
    ack_en  = 1'b1;
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    drive_m1(0, 0, 0, 8'h00, 8'h00);

    // ---------------- reset state, even with a request pending
    tick();
    drive_m0(1, 1, 1, 8'h10, 8'hA5);
    #1;
    check("rst_gnt",   32'(gnt_o),    32'h0);
    check("rst_s_cyc", 32'(s_cyc_o),  32'h0);
    check("rst_s_stb", 32'(s_stb_o),  32'h0);
    check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    tick();
    rst_i   = 1'b0;
    preload = 1'b0;

    // ---------------- single write: m0 writes 0xA5 to 0x10
    tick();
    drive_m0(1, 1, 1, 8'h10, 8'hA5);
    #1;
    check("wr_req_gnt", 32'(gnt_o),   32'h0);
    check("wr_req_cyc", 32'(s_cyc_o), 32'h0);
    tick(); #1;
    check("wr_gnt",    32'(gnt_o),    32'h1);
    check("wr_s_cyc",  32'(s_cyc_o),  32'h1);
    check("wr_s_we",   32'(s_we_o),   32'h1);
    check("wr_s_adr",  32'(s_adr_o),  32'h10);
    check("wr_s_dat",  32'(s_dat_o),  32'hA5);
    check("wr_m0_ack", 32'(m0_ack_o), 32'h1);
    check("wr_m0_err", 32'(m0_err_o), 32'h0);
    check("wr_m1_ack", 32'(m1_ack_o), 32'h0);
    tick();
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    #1;
    check("wr_hold_gnt", 32'(gnt_o),    32'h1);
    check("wr_drop_cyc", 32'(s_cyc_o),  32'h0);
    check("wr_mem",      32'(mem[8'h10]), 32'hA5);
    tick(); #1;
    check("wr_idle_gnt", 32'(gnt_o), 32'h0);

    // ---------------- tie after reset: m0 first, then direct handoff to m1
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    tick();
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    drive_m1(1, 1, 0, 8'h20, 8'h00);
    #1;
    check("tie_req_gnt", 32'(gnt_o), 32'h0);
    tick(); #1;
    check("tie_gnt0",    32'(gnt_o),    32'h1);
    check("tie_s_adr0",  32'(s_adr_o),  32'h10);
    check("tie_m0_wait", 32'(m0_ack_o), 32'h0);
    tick(); #1;
    check("tie_m0_ack",  32'(m0_ack_o), 32'h1);
    check("tie_m0_dat",  32'(m0_dat_o), 32'hA5);
    check("tie_m1_ack0", 32'(m1_ack_o), 32'h0);
    check("tie_m1_dat0", 32'(m1_dat_o), 32'h00);
    tick();
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    #1;
    check("tie_drop_gnt", 32'(gnt_o), 32'h1);
    tick(); #1;
    check("tie_gnt1",    32'(gnt_o),   32'h2);
    check("tie_s_adr1",  32'(s_adr_o), 32'h20);
    check("tie_m1_wait", 32'(m1_ack_o), 32'h0);
    tick(); #1;
    check("tie_m1_ack",  32'(m1_ack_o), 32'h1);
    check("tie_m1_dat",  32'(m1_dat_o), 32'h1C);
    check("tie_m0_ack1", 32'(m0_ack_o), 32'h0);
    tick();
    drive_m1(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("tie_idle", 32'(gnt_o), 32'h0);
    // second tie: m1 owned last, so m0 wins
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    drive_m1(1, 1, 0, 8'h20, 8'h00);
    tick(); #1;
    check("tie2_gnt", 32'(gnt_o), 32'h1);
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    drive_m1(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("tie2_idle", 32'(gnt_o), 32'h0);
    // third tie: m0 owned last, so m1 wins
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    drive_m1(1, 1, 0, 8'h20, 8'h00);
    tick(); #1;
    check("tie3_gnt", 32'(gnt_o), 32'h2);
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    drive_m1(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("tie3_idle", 32'(gnt_o), 32'h0);

    // ---------------- locked burst: m1 reads 0x00..0x03 while m0 waits
    drive_m1(1, 1, 0, 8'h00, 8'h00);
    tick();
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("burst_gnt_a", 32'(gnt_o),    32'h2);
      check("burst_wait",  32'(m1_ack_o), 32'h0);
      tick(); #1;
      check("burst_gnt_b", 32'(gnt_o),    32'h2);
      check("burst_ack",   32'(m1_ack_o), 32'h1);
      check("burst_dat",   32'(m1_dat_o), 32'(8'h3C + 8'(i)));
      check("burst_m0",    32'(m0_ack_o), 32'h0);
      tick();
      if (i < 3) drive_m1(1, 1, 0, 8'(i + 1), 8'h00);
      else       drive_m1(0, 0, 0, 8'h00, 8'h00);
    end
    #1;
    check("burst_rel_gnt", 32'(gnt_o), 32'h2);
    tick(); #1;
    check("burst_m0_gnt",  32'(gnt_o),    32'h1);
    check("burst_m0_wait", 32'(m0_ack_o), 32'h0);
    tick(); #1;
    check("burst_m0_ack",  32'(m0_ack_o), 32'h1);
    check("burst_m0_dat",  32'(m0_dat_o), 32'hA5);
    tick();
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("burst_idle", 32'(gnt_o), 32'h0);

    // ---------------- timeout: memory never acks, m0 reads
    ack_en    = 1'b0;
    first_err = 0;
    err_cnt   = 0;
    ack_seen  = 1'b0;
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    // n counts granted cycles, n = 1 being the first cycle with gnt_o = 01
    for (int n = 1; n <= 20; n++) begin
      tick(); #1;
      if (m0_err_o) begin
        err_cnt++;
        if (first_err == 0) first_err = n;
      end
      if (m0_ack_o || m1_err_o) ack_seen = 1'b1;
    end
    check("to_err_cycle", 32'(first_err), 32'd15);
    check("to_err_count", 32'(err_cnt),   32'd1);
    check("to_no_ack",    32'(ack_seen),  32'h0);
    check("to_gnt_held",  32'(gnt_o),     32'h1);
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("to_idle", 32'(gnt_o), 32'h0);
    ack_en = 1'b1;

    // ---------------- reset between read strobe and its ack
    drive_m0(1, 1, 0, 8'h10, 8'h00);
    tick(); #1;
    check("rr_gnt",   32'(gnt_o),   32'h1);
    check("rr_s_cyc", 32'(s_cyc_o), 32'h1);
    #1 rst_i = 1'b1;
    #1;
    check("rr_async_gnt", 32'(gnt_o),    32'h0);
    check("rr_async_cyc", 32'(s_cyc_o),  32'h0);
    check("rr_async_ack", 32'(m0_ack_o), 32'h0);
    check("rr_async_err", 32'(m0_err_o), 32'h0);
    tick(); #1;
    check("rr_held_gnt", 32'(gnt_o),    32'h0);
    check("rr_held_ack", 32'(m0_ack_o), 32'h0);
    check("rr_held_err", 32'(m0_err_o), 32'h0);
    rst_i = 1'b0;
    #1;
    check("rr_rel_gnt", 32'(gnt_o), 32'h0);
    tick(); #1;
    check("rr_restart_gnt", 32'(gnt_o), 32'h1);
    drive_m0(0, 0, 0, 8'h00, 8'h00);
    tick(); #1;
    check("rr_idle", 32'(gnt_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
